// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM states and request error classification
// for the handshaked byte-addressable data memory.
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Any one of illegal size, misalignment or an address beyond the array
  // turns the transaction into an error response.
  function automatic logic access_error(
    input logic [1:0]  size,
    input logic [31:0] addr,
    input int          addr_width
  );
    logic [31:0] hi_mask;
    logic        bad_size;
    logic        misaligned;
    logic        out_of_range;
    hi_mask      = 32'hFFFF_FFFF << addr_width;
    bad_size     = (size == 2'b11);
    misaligned   = ((size == SIZE_HALF) && addr[0]) ||
                   ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
    out_of_range = |(addr & hi_mask);
    return bad_size | misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Big-endian lane steering: store data to per-byte enables and lane
// data, and raw word bytes back to an extended load result.
module byte_lane_align
  import data_memory_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data,
  input  logic [31:0] raw_word,
  input  logic        load_unsigned,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // byte_en[3] / lane_data[31:24] map to the lowest address of the word.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wdata;
    case (size)
      SIZE_BYTE: begin
        byte_en   = 4'b1000 >> offset;
        lane_data = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        byte_en   = offset[1] ? 4'b0011 : 4'b1100;
        lane_data = {2{wdata[15:0]}};
      end
      SIZE_WORD: byte_en = 4'b1111;
      default:   byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    sel_byte = 8'h00;
    case (offset)
      2'd0: sel_byte = raw_word[31:24];
      2'd1: sel_byte = raw_word[23:16];
      2'd2: sel_byte = raw_word[15:8];
      2'd3: sel_byte = raw_word[7:0];
      default: sel_byte = 8'h00;
    endcase
    sel_half = offset[1] ? raw_word[15:0] : raw_word[31:16];
  end

  always_comb begin
    load_data = 32'h0;
    case (size)
      SIZE_BYTE: load_data = {{24{~load_unsigned & sel_byte[7]}}, sel_byte};
      SIZE_HALF: load_data = {{16{~load_unsigned & sel_half[15]}}, sel_half};
      SIZE_WORD: load_data = raw_word;
      default:   load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked data memory: one request at a time, optional wait states,
// single-cycle response pulse with error flag.
//
// state  | meaning
// IDLE   | ready; captures request when req_valid
// WAIT   | wait_cnt counts WAIT_CYCLES-1 down to 0
// ACCESS | store commits / load result and error registered
// RESP   | resp_valid pulse
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        cap_write;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [7:0]  mem [DEPTH];
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0] raw_word;
  logic [3:0]  byte_en;
  logic [31:0] lane_data;
  logic [31:0] load_data;
  logic        err;

  assign word_idx = cap_addr[ADDR_WIDTH-1:2];
  assign raw_word = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                     mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};
  assign err      = access_error(cap_size, cap_addr, ADDR_WIDTH);

  byte_lane_align u_align (
    .size          (cap_size),
    .offset        (cap_addr[1:0]),
    .wdata         (cap_wdata),
    .byte_en       (byte_en),
    .lane_data     (lane_data),
    .raw_word      (raw_word),
    .load_unsigned (cap_unsigned),
    .load_data     (load_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      cap_write    <= 1'b0;
      cap_size     <= SIZE_BYTE;
      cap_unsigned <= 1'b0;
      cap_addr     <= 32'h0;
      cap_wdata    <= 32'h0;
      resp_rdata   <= 32'h0;
      resp_error   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        cap_write    <= req_write;
        cap_size     <= req_size;
        cap_unsigned <= req_unsigned;
        cap_addr     <= req_addr;
        cap_wdata    <= req_wdata;
        wait_cnt     <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == ACCESS) begin
        resp_error <= err;
        resp_rdata <= (err || cap_write) ? 32'h0 : load_data;
      end
    end
  end

  // Array is deliberately not reset; a reset on the ACCESS edge drops the store.
  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && cap_write && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[3-i]) mem[{word_idx, 2'(i)}] <= lane_data[31-8*i -: 8];
      end
    end
  end

endmodule
